// File: rtl/lbm_stream_addr_gen_pkg.sv
// Shared D2Q9 definitions for the grid-walk sequencer and its consumers.
//   EX/EY      : lattice velocity components indexed by direction number
//   dir_e      : direction enumeration DIR_0..DIR_8
//   bclass_e   : boundary class of a cell, shared with the main controller
//   addr_invalid / nbr_index : helpers for off-grid encoding and constant neighbour lookup
package lbm_stream_addr_gen_pkg;

  localparam int unsigned NumDir = 9;

  typedef enum logic [3:0] {
    DIR_0, DIR_1, DIR_2, DIR_3, DIR_4, DIR_5, DIR_6, DIR_7, DIR_8
  } dir_e;

  typedef enum logic [2:0] {
    BcNone, BcLid, BcBottom, BcLeft, BcRight
  } bclass_e;

  localparam int EX [NumDir] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int EY [NumDir] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  // All-ones pattern of the given width; marks an off-grid destination.
  function automatic logic [31:0] addr_invalid(int unsigned width);
    logic [63:0] ones;
    ones = (64'd1 << width) - 64'd1;
    return ones[31:0];
  endfunction

  // Linear neighbour index of (x,y) in direction k, or -1 when off-grid.
  function automatic int nbr_index(int nx, int ny, int x, int y, int k);
    int tx;
    int ty;
    tx = x + EX[k];
    ty = y + EY[k];
    if (tx < 0 || tx >= nx || ty < 0 || ty >= ny) return -1;
    return ty * nx + tx;
  endfunction

endpackage

// File: rtl/lbm_stream_addr_gen_if.sv
// Control/result bundle between the controller (master) and the grid-walk sequencer (slave).
//   clear, step             : controller -> sequencer
//   cell_*, boundary flags,
//   stream_addr/valid, etc. : sequencer -> controller
interface lbm_stream_addr_gen_if #(
  parameter int unsigned NX         = 16,
  parameter int unsigned NY         = 16,
  parameter int unsigned ITER_WIDTH = 16
);
  localparam int unsigned AW  = $clog2(NX * NY);
  localparam int unsigned AW2 = AW + 1;

  logic                          clear;
  logic                          step;
  logic [AW-1:0]                 cell_addr;
  logic [$clog2(NX)-1:0]         cell_x;
  logic [$clog2(NY)-1:0]         cell_y;
  logic                          LID;
  logic                          BOTTOM_WALL;
  logic                          LEFT_WALL;
  logic                          RIGHT_WALL;
  logic [8:0][AW2-1:0]           stream_addr;
  logic [8:0]                    stream_valid;
  logic                          addr_valid;
  logic                          last_cell;
  logic                          sweep_done;
  logic [ITER_WIDTH-1:0]         iter_count;

  modport master (
    output clear, step,
    input  cell_addr, cell_x, cell_y, LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL,
    input  stream_addr, stream_valid, addr_valid, last_cell, sweep_done, iter_count
  );

  modport slave (
    input  clear, step,
    output cell_addr, cell_x, cell_y, LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL,
    output stream_addr, stream_valid, addr_valid, last_cell, sweep_done, iter_count
  );
endinterface

// File: rtl/lbm_stream_addr_gen_neighbor.sv
// Combinational streaming destination for one D2Q9 direction.
//   x_i, y_i : source cell
//   addr_o   : destination linear address, all-ones when off-grid
//   valid_o  : destination lies on the grid
module lbm_stream_addr_gen_neighbor #(
  parameter int unsigned NX = 16,
  parameter int unsigned NY = 16,
  parameter int          EX = 0,
  parameter int          EY = 0
) (
  input  logic [$clog2(NX)-1:0]      x_i,
  input  logic [$clog2(NY)-1:0]      y_i,
  output logic [$clog2(NX*NY):0]     addr_o,
  output logic                       valid_o
);
  localparam int unsigned AW2 = $clog2(NX * NY) + 1;
  // One extra bit beyond the stream width so a -1 offset at the edge stays negative.
  localparam int unsigned SW  = AW2 + 1;

  localparam logic signed [SW-1:0] ExS = SW'(EX);
  localparam logic signed [SW-1:0] EyS = SW'(EY);
  localparam logic signed [SW-1:0] NxS = SW'(NX);
  localparam logic signed [SW-1:0] NyS = SW'(NY);

  logic signed [SW-1:0] tx;
  logic signed [SW-1:0] ty;
  logic signed [SW-1:0] lin;

  always_comb begin
    tx      = signed'(SW'(x_i)) + ExS;
    ty      = signed'(SW'(y_i)) + EyS;
    valid_o = (tx >= 0) && (tx < NxS) && (ty >= 0) && (ty < NyS);
    lin     = ty * NxS + tx;
    addr_o  = valid_o ? AW2'(lin) : '1;
  end

endmodule

// File: rtl/lbm_stream_addr_gen.sv
// Grid-walk sequencer for the D2Q9 LBM core.
//   Clk, Reset : clock and asynchronous active-low reset
//   bus        : slave side of lbm_stream_addr_gen_if (clear/step in; cell position, boundary
//                class, nine stream addresses + valids, last_cell, sweep_done, iter_count out)
// All outputs are registered from the next-position values so they change on the same edge
// as the position itself.
module lbm_stream_addr_gen
  import lbm_stream_addr_gen_pkg::*;
#(
  parameter int unsigned NX         = 16,
  parameter int unsigned NY         = 16,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  lbm_stream_addr_gen_if.slave  bus
);
  localparam int unsigned GRID_DIM = NX * NY;
  localparam int unsigned AW       = $clog2(GRID_DIM);
  localparam int unsigned AW2      = AW + 1;
  localparam int unsigned XW       = $clog2(NX);
  localparam int unsigned YW       = $clog2(NY);

  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic                   sweep_q, sweep_d;
  logic [AW-1:0]          cell_addr_q, cell_addr_d;
  logic                   last_cell_q, last_cell_d;
  bclass_e                bclass_q, bclass_d;
  logic [8:0][AW2-1:0]    stream_addr_q, nbr_addr;
  logic [8:0]             stream_valid_q, nbr_valid;
  logic                   addr_valid_q;
  logic                   at_last;

  // Reset image of the stream outputs: neighbours of cell (0,0).
  function automatic logic [AW2-1:0] rst_addr(int k);
    int idx;
    idx = nbr_index(NX, NY, 0, 0, k);
    return (idx < 0) ? AW2'(addr_invalid(AW2)) : AW2'(idx);
  endfunction

  assign at_last = (x_q == XW'(NX - 1)) && (y_q == YW'(NY - 1));

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    iter_d  = iter_q;
    sweep_d = 1'b0;
    if (bus.clear) begin
      x_d    = '0;
      y_d    = '0;
      iter_d = '0;
    end else if (bus.step) begin
      if (at_last) begin
        x_d     = '0;
        y_d     = '0;
        iter_d  = iter_q + 1'b1;
        sweep_d = 1'b1;
      end else if (x_q == XW'(NX - 1)) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    cell_addr_d = AW'(32'(y_d) * NX + 32'(x_d));
    last_cell_d = (cell_addr_d == AW'(GRID_DIM - 1));
    // Priority order makes the classes mutually exclusive: bottom row owns its corners,
    // side walls own the top corners, LID is only the top-row interior.
    if (y_d == '0)                     bclass_d = BcBottom;
    else if (x_d == '0)                bclass_d = BcLeft;
    else if (x_d == XW'(NX - 1))       bclass_d = BcRight;
    else if (y_d == YW'(NY - 1))       bclass_d = BcLid;
    else                               bclass_d = BcNone;
  end

  for (genvar k = 0; k < NumDir; k++) begin : g_nbr
    lbm_stream_addr_gen_neighbor #(
      .NX (NX),
      .NY (NY),
      .EX (EX[k]),
      .EY (EY[k])
    ) u_nbr (
      .x_i     (x_d),
      .y_i     (y_d),
      .addr_o  (nbr_addr[k]),
      .valid_o (nbr_valid[k])
    );
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_q          <= '0;
      y_q          <= '0;
      iter_q       <= '0;
      sweep_q      <= 1'b0;
      cell_addr_q  <= '0;
      last_cell_q  <= (GRID_DIM == 1);
      bclass_q     <= BcBottom;
      addr_valid_q <= 1'b1;
      for (int k = 0; k < NumDir; k++) begin
        stream_addr_q[k]  <= rst_addr(k);
        stream_valid_q[k] <= (nbr_index(NX, NY, 0, 0, k) >= 0);
      end
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      iter_q         <= iter_d;
      sweep_q        <= sweep_d;
      cell_addr_q    <= cell_addr_d;
      last_cell_q    <= last_cell_d;
      bclass_q       <= bclass_d;
      addr_valid_q   <= 1'b1;
      stream_addr_q  <= nbr_addr;
      stream_valid_q <= nbr_valid;
    end
  end

  assign bus.cell_addr    = cell_addr_q;
  assign bus.cell_x       = x_q;
  assign bus.cell_y       = y_q;
  assign bus.LID          = (bclass_q == BcLid);
  assign bus.BOTTOM_WALL  = (bclass_q == BcBottom);
  assign bus.LEFT_WALL    = (bclass_q == BcLeft);
  assign bus.RIGHT_WALL   = (bclass_q == BcRight);
  assign bus.stream_addr  = stream_addr_q;
  assign bus.stream_valid = stream_valid_q;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.last_cell    = last_cell_q;
  assign bus.sweep_done   = sweep_q;
  assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_lbm_stream_addr_gen.sv
// Directed bench for lbm_stream_addr_gen on a 16x16 grid: table of cumulative walk points
// with hand-computed outputs, then sequences for wrap, held step, async reset and clear.
module tb_lbm_stream_addr_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lbm_stream_addr_gen_if #(.NX(16), .NY(16), .ITER_WIDTH(16)) bus ();

  lbm_stream_addr_gen #(.NX(16), .NY(16), .ITER_WIDTH(16)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int             steps;
    int             addr;
    int             x;
    int             y;
    logic [3:0]     flags;   // {LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL}
    logic           last;
    logic [8:0]     valid;
    logic [8:0][8:0] sa;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(int steps, int addr, int x, int y, logic [3:0] flags, logic last,
                              logic [8:0] valid, int a0, int a1, int a2, int a3, int a4,
                              int a5, int a6, int a7, int a8);
    vec_t v;
    v.steps = steps; v.addr = addr; v.x = x; v.y = y;
    v.flags = flags; v.last = last; v.valid = valid;
    v.sa[0] = 9'(a0); v.sa[1] = 9'(a1); v.sa[2] = 9'(a2);
    v.sa[3] = 9'(a3); v.sa[4] = 9'(a4); v.sa[5] = 9'(a5);
    v.sa[6] = 9'(a6); v.sa[7] = 9'(a7); v.sa[8] = 9'(a8);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.LID, bus.BOTTOM_WALL, bus.LEFT_WALL, bus.RIGHT_WALL};
  endfunction

  // Drive step high for n edges, then drop it; returns at edge+1.
  task automatic run_steps(input int n);
    bus.step = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.step = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.clear = 1'b0;
    bus.step  = 1'b0;

    // Cumulative walk points from reset.
    vecs[0] = mk(0,   0,   0,  0,  4'b0100, 1'b0, 9'b000100111,
                 0,   1,   16,  511, 511, 17,  511, 511, 511);
    vecs[1] = mk(15,  15,  15, 0,  4'b0100, 1'b0, 9'b001001101,
                 15,  511, 31,  14,  511, 511, 30,  511, 511);
    vecs[2] = mk(1,   16,  0,  1,  4'b0010, 1'b0, 9'b100110111,
                 16,  17,  32,  511, 0,   33,  511, 511, 1);
    vecs[3] = mk(1,   17,  1,  1,  4'b0000, 1'b0, 9'b111111111,
                 17,  18,  33,  16,  1,   34,  32,  0,   2);
    vecs[4] = mk(230, 247, 7,  15, 4'b1000, 1'b0, 9'b110011011,
                 247, 248, 511, 246, 231, 511, 511, 230, 232);
    vecs[5] = mk(8,   255, 15, 15, 4'b0001, 1'b1, 9'b010011001,
                 255, 511, 511, 254, 239, 511, 511, 238, 511);

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].steps > 0) run_steps(vecs[i].steps);
      chk($sformatf("v%0d cell_addr", i), 32'(bus.cell_addr), vecs[i].addr);
      chk($sformatf("v%0d cell_x", i), 32'(bus.cell_x), vecs[i].x);
      chk($sformatf("v%0d cell_y", i), 32'(bus.cell_y), vecs[i].y);
      chk($sformatf("v%0d flags", i), 32'(flags_now()), 32'(vecs[i].flags));
      chk($sformatf("v%0d last_cell", i), 32'(bus.last_cell), 32'(vecs[i].last));
      chk($sformatf("v%0d stream_valid", i), 32'(bus.stream_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d addr_valid", i), 32'(bus.addr_valid), 32'd1);
      chk($sformatf("v%0d sweep_done", i), 32'(bus.sweep_done), 32'd0);
      chk($sformatf("v%0d iter_count", i), 32'(bus.iter_count), 32'd0);
      for (int k = 0; k < 9; k++)
        chk($sformatf("v%0d stream_addr%0d", i, k), 32'(bus.stream_addr[k]),
            32'(vecs[i].sa[k]));
    end

    // Wrap from cell 255: one-cycle sweep_done, iter_count 0 -> 1.
    run_steps(1);
    chk("wrap cell_addr", 32'(bus.cell_addr), 32'd0);
    chk("wrap sweep_done", 32'(bus.sweep_done), 32'd1);
    chk("wrap iter_count", 32'(bus.iter_count), 32'd1);
    chk("wrap last_cell", 32'(bus.last_cell), 32'd0);
    chk("wrap bottom", 32'(flags_now()), 32'b0100);
    @(posedge clk); #1;
    chk("wrap pulse end", 32'(bus.sweep_done), 32'd0);
    chk("hold cell_addr", 32'(bus.cell_addr), 32'd0);
    chk("hold iter_count", 32'(bus.iter_count), 32'd1);

    // Step held high for a full sweep.
    bus.step = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    chk("held cell 255", 32'(bus.cell_addr), 32'd255);
    chk("held no sweep", 32'(bus.sweep_done), 32'd0);
    chk("held last_cell", 32'(bus.last_cell), 32'd1);
    @(posedge clk); #1;
    chk("held wrap cell", 32'(bus.cell_addr), 32'd0);
    chk("held wrap sweep", 32'(bus.sweep_done), 32'd1);
    chk("held iter 2", 32'(bus.iter_count), 32'd2);
    @(posedge clk); #1;
    chk("held cell 1", 32'(bus.cell_addr), 32'd1);
    chk("held sweep drop", 32'(bus.sweep_done), 32'd0);

    // Async reset mid-walk with step still high.
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst cell_addr", 32'(bus.cell_addr), 32'd0);
    chk("rst cell_x", 32'(bus.cell_x), 32'd0);
    chk("rst iter_count", 32'(bus.iter_count), 32'd0);
    chk("rst bottom", 32'(flags_now()), 32'b0100);
    chk("rst stream_valid", 32'(bus.stream_valid), 32'b000100111);
    chk("rst stream_addr2", 32'(bus.stream_addr[2]), 32'd16);
    chk("rst stream_addr3", 32'(bus.stream_addr[3]), 32'd511);
    chk("rst addr_valid", 32'(bus.addr_valid), 32'd1);
    @(posedge clk); #1;
    chk("rst held cell", 32'(bus.cell_addr), 32'd0);
    bus.step = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // One sweep plus 40 cells, then clear and step together.
    run_steps(296);
    chk("pre-clear cell", 32'(bus.cell_addr), 32'd40);
    chk("pre-clear iter", 32'(bus.iter_count), 32'd1);
    bus.clear = 1'b1;
    bus.step  = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.step  = 1'b0;
    chk("clear cell", 32'(bus.cell_addr), 32'd0);
    chk("clear iter", 32'(bus.iter_count), 32'd0);
    chk("clear no sweep", 32'(bus.sweep_done), 32'd0);
    chk("clear stream_addr5", 32'(bus.stream_addr[5]), 32'd17);
    @(posedge clk); #1;
    chk("clear after sweep", 32'(bus.sweep_done), 32'd0);
    chk("clear after cell", 32'(bus.cell_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
